icache_refill_ctrl: RTL and testbench

- Direct-mapped instruction cache with block-refill state machine; sits directly upstream of the fetch stage.
- Takes the PC from fetch, returns the instruction word and the hit bit that fetch forwards to IF/ID, ID/EX, EX/MEM and MEM/WB as the pipeline stall qualifier.
- On a miss it fetches a whole block from main memory over a request/ack + word-stream interface, installs it, then hits.

---
 rtl/icache_refill_ctrl_pkg.sv | 23 ++
 rtl/icache_refill_ctrl_if.sv | 28 ++
 rtl/icache_line_store.sv | 68 ++++++
 rtl/icache_refill_ctrl.sv | 123 ++++++++++++
 tb/tb_icache_refill_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared state encoding and default geometry for the instruction-cache refill controller.
package icache_refill_ctrl_pkg;

  localparam int NUM_LINES_DEF   = 32;
  localparam int BLOCK_WORDS_DEF = 4;
  localparam int ADDR_W_DEF      = 32;

  localparam int OFFSET_W = 2 + $clog2(BLOCK_WORDS_DEF);
  localparam int INDEX_W  = $clog2(NUM_LINES_DEF);
  localparam int TAG_W    = ADDR_W_DEF - OFFSET_W - INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    INSTALL
  } refill_state_e;

  function automatic int offsetWidth(input int blockWords);
    return 2 + $clog2(blockWords);
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled for the top-level port.
interface icache_refill_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] pc;
  logic              flush;
  logic [31:0]       instruction;
  logic              hit;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic [15:0]       miss_count;

  // The cache itself is the slave; fetch plus main memory form the master side.
  modport slave (
    input  pc, flush, mem_ack, mem_rvalid, mem_rdata,
    output instruction, hit, mem_req, mem_addr, miss_count
  );

  modport master (
    output pc, flush, mem_ack, mem_rvalid, mem_rdata,
    input  instruction, hit, mem_req, mem_addr, miss_count
  );

endinterface

// File: rtl/icache_line_store.sv
// Tag/valid/data storage for a direct-mapped cache: combinational read, word write, line install.
module icache_line_store
  import icache_refill_ctrl_pkg::*;
#(
  parameter int NUM_LINES   = NUM_LINES_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int TAG_BITS    = TAG_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic [$clog2(NUM_LINES)-1:0]   rdIndex_i,
  input  logic [$clog2(BLOCK_WORDS)-1:0] rdWord_i,
  output logic [31:0]                    rdData_o,
  output logic [TAG_BITS-1:0]            rdTag_o,
  output logic                           rdValid_o,
  input  logic                           wrEn_i,
  input  logic [$clog2(NUM_LINES)-1:0]   wrIndex_i,
  input  logic [$clog2(BLOCK_WORDS)-1:0] wrWord_i,
  input  logic [31:0]                    wrData_i,
  input  logic                           invEn_i,
  input  logic [$clog2(NUM_LINES)-1:0]   invIndex_i,
  input  logic                           installEn_i,
  input  logic [$clog2(NUM_LINES)-1:0]   installIndex_i,
  input  logic [TAG_BITS-1:0]            installTag_i
);

  logic [31:0]         data_q [NUM_LINES][BLOCK_WORDS];
  logic [TAG_BITS-1:0] tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;

  assign rdData_o  = data_q[rdIndex_i][rdWord_i];
  assign rdTag_o   = tag_q[rdIndex_i];
  assign rdValid_o = valid_q[rdIndex_i];

  // Install is applied after flush so a line finishing its refill survives a concurrent flush.
  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (invEn_i) begin
      valid_d[invIndex_i] = 1'b0;
    end
    if (installEn_i) begin
      valid_d[installIndex_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload arrays carry no reset; the valid bits alone decide whether they mean anything.
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      data_q[wrIndex_i][wrWord_i] <= wrData_i;
    end
    if (installEn_i) begin
      tag_q[installIndex_i] <= installTag_i;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache front end: zero-latency lookup plus a block-refill state machine.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int NUM_LINES   = NUM_LINES_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  icache_refill_ctrl_if.slave bus
);

  localparam int OFF_W    = offsetWidth(BLOCK_WORDS);
  localparam int WORD_W   = $clog2(BLOCK_WORDS);
  localparam int IDX_W    = $clog2(NUM_LINES);
  localparam int TAG_BITS = ADDR_W - OFF_W - IDX_W;

  refill_state_e     state_q;
  logic [WORD_W-1:0] wordCnt_q;
  logic              memReq_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [15:0]       missCount_q;

  logic [WORD_W-1:0]   pcWord;
  logic [IDX_W-1:0]    pcIndex;
  logic [TAG_BITS-1:0] pcTag;
  logic [IDX_W-1:0]    fillIndex;
  logic [TAG_BITS-1:0] fillTag;
  logic                unusedPcBits;

  logic [31:0]         rdData;
  logic [TAG_BITS-1:0] rdTag;
  logic                rdValid;
  logic                hitNow;
  logic                missNow;

  assign pcWord       = bus.pc[OFF_W-1:2];
  assign pcIndex      = bus.pc[OFF_W+IDX_W-1:OFF_W];
  assign pcTag        = bus.pc[ADDR_W-1:OFF_W+IDX_W];
  assign fillIndex    = memAddr_q[OFF_W+IDX_W-1:OFF_W];
  assign fillTag      = memAddr_q[ADDR_W-1:OFF_W+IDX_W];
  assign unusedPcBits = ^bus.pc[1:0];

  // A flush in IDLE suppresses the hit and therefore counts as a miss in that same cycle.
  assign hitNow  = rst_n && (state_q == IDLE) && !bus.flush && rdValid && (rdTag == pcTag);
  assign missNow = rst_n && (state_q == IDLE) && !hitNow;

  assign bus.hit         = hitNow;
  assign bus.instruction = rst_n ? rdData : 32'd0;
  assign bus.mem_req     = memReq_q;
  assign bus.mem_addr    = memAddr_q;
  assign bus.miss_count  = missCount_q;

  icache_line_store #(
    .NUM_LINES  (NUM_LINES),
    .BLOCK_WORDS(BLOCK_WORDS),
    .TAG_BITS   (TAG_BITS)
  ) u_store (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (bus.flush),
    .rdIndex_i     (pcIndex),
    .rdWord_i      (pcWord),
    .rdData_o      (rdData),
    .rdTag_o       (rdTag),
    .rdValid_o     (rdValid),
    .wrEn_i        (rst_n && (state_q == FILL) && bus.mem_rvalid),
    .wrIndex_i     (fillIndex),
    .wrWord_i      (wordCnt_q),
    .wrData_i      (bus.mem_rdata),
    .invEn_i       (missNow),
    .invIndex_i    (pcIndex),
    .installEn_i   (rst_n && (state_q == INSTALL)),
    .installIndex_i(fillIndex),
    .installTag_i  (fillTag)
  );

  // The latched block address drives both the memory request and the fill/install line,
  // so pc may wander freely once a refill has started.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wordCnt_q   <= '0;
      memReq_q    <= 1'b0;
      memAddr_q   <= '0;
      missCount_q <= 16'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (missNow) begin
            state_q     <= REQ;
            memReq_q    <= 1'b1;
            memAddr_q   <= {pcTag, pcIndex, {OFF_W{1'b0}}};
            missCount_q <= missCount_q + 16'd1;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            state_q   <= FILL;
            memReq_q  <= 1'b0;
            wordCnt_q <= '0;
          end
        end
        FILL: begin
          if (bus.mem_rvalid) begin
            wordCnt_q <= wordCnt_q + 1'b1;
            if (wordCnt_q == WORD_W'(BLOCK_WORDS - 1)) begin
              state_q <= INSTALL;
            end
          end
        end
        INSTALL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: directed vector table, hand sequences, random run vs model.
module tb_icache_refill_ctrl;
  import icache_refill_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  icache_refill_ctrl_if #(.ADDR_W(32)) bus ();

  icache_refill_ctrl #(
    .NUM_LINES  (32),
    .BLOCK_WORDS(4),
    .ADDR_W     (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        ack;
    logic        rvalid;
    logic [31:0] rdata;
    logic        expHit;
    logic [31:0] expInstr;
    logic        expReq;
    logic [31:0] expAddr;
    logic [15:0] expCount;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state for the random run
  bit          mValid[32];
  logic [22:0] mTag[32];
  logic [31:0] mData[32][4];
  bit          mBusy;
  bit          mAcked;
  int          mGot;
  int          mAckWait;
  logic [31:0] mBlock;
  logic [31:0] mBuf[4];
  logic [15:0] mCount;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  // Inputs change on the falling edge and outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic rstN, input logic [31:0] pc, input logic flush,
                               input logic ack, input logic rvalid, input logic [31:0] rdata);
    @(negedge clk);
    rst_n          = rstN;
    bus.pc         = pc;
    bus.flush      = flush;
    bus.mem_ack    = ack;
    bus.mem_rvalid = rvalid;
    bus.mem_rdata  = rdata;
    #1;
  endtask

  task automatic addVec(input logic [31:0] pc, input logic flush, input logic ack, input logic rvalid,
                        input logic [31:0] rdata, input logic expHit, input logic [31:0] expInstr,
                        input logic expReq, input logic [31:0] expAddr, input logic [15:0] expCount);
    vec_t v;
    v.pc = pc; v.flush = flush; v.ack = ack; v.rvalid = rvalid; v.rdata = rdata;
    v.expHit = expHit; v.expInstr = expInstr; v.expReq = expReq; v.expAddr = expAddr;
    v.expCount = expCount;
    vecs.push_back(v);
  endtask

  task automatic addFill(input logic [31:0] pc, input logic [31:0] base, input logic [15:0] cnt);
    for (int k = 0; k < 4; k++) addVec(pc, 0, 0, 1, base + 32'(k), 0, 0, 0, 0, cnt);
    addVec(pc, 0, 0, 1, 32'hBEEF, 0, 0, 0, 0, cnt);
  endtask

  task automatic doReset();
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0);
    checkOutput("reset hit", 32'(bus.hit), 32'h0);
    checkOutput("reset instruction", bus.instruction, 32'h0);
    applyStimulus(0, 32'h0, 0, 0, 1, 32'h5555);
    checkOutput("reset mem_req", 32'(bus.mem_req), 32'h0);
    checkOutput("reset mem_addr", bus.mem_addr, 32'h0);
    checkOutput("reset miss_count", 32'(bus.miss_count), 32'h0);
  endtask

  initial begin
    int pat[7];
    int wi;
    logic [31:0] pcv;
    logic [31:0] rd;
    logic        fl, ack, rv, expHit, expReq, streaming;
    logic [4:0]  idx;
    logic [4:0]  li;

    bus.pc = '0; bus.flush = 0; bus.mem_ack = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;

    // Directed table: cold miss, conflict eviction, byte offset, flush in IDLE
    addVec(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(32'h0, 0, 1, 1, 32'hDEAD, 0, 0, 1, 32'h0, 1);
    addFill(32'h0, 32'hA0, 1);
    addVec(32'h0, 0, 0, 0, 0, 1, 32'hA0, 0, 0, 1);
    addVec(32'hC, 0, 0, 1, 32'hCAFE, 1, 32'hA3, 0, 0, 1);
    addVec(32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(32'h200, 0, 1, 0, 0, 0, 0, 1, 32'h200, 2);
    addFill(32'h200, 32'hB0, 2);
    addVec(32'h200, 0, 0, 0, 0, 1, 32'hB0, 0, 0, 2);
    addVec(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    addVec(32'h0, 0, 1, 0, 0, 0, 0, 1, 32'h0, 3);
    addFill(32'h0, 32'hA0, 3);
    addVec(32'h3, 0, 0, 0, 0, 1, 32'hA0, 0, 0, 3);
    addVec(32'h4, 1, 0, 0, 0, 0, 0, 0, 0, 3);
    addVec(32'h4, 0, 1, 0, 0, 0, 0, 1, 32'h0, 4);
    addFill(32'h4, 32'hA0, 4);
    addVec(32'h4, 0, 0, 0, 0, 1, 32'hA1, 0, 0, 4);

    doReset();
    foreach (vecs[i]) begin
      applyStimulus(1, vecs[i].pc, vecs[i].flush, vecs[i].ack, vecs[i].rvalid, vecs[i].rdata);
      checkOutput($sformatf("vec%0d hit", i), 32'(bus.hit), 32'(vecs[i].expHit));
      if (vecs[i].expHit) checkOutput($sformatf("vec%0d instruction", i), bus.instruction, vecs[i].expInstr);
      checkOutput($sformatf("vec%0d mem_req", i), 32'(bus.mem_req), 32'(vecs[i].expReq));
      if (vecs[i].expReq) checkOutput($sformatf("vec%0d mem_addr", i), bus.mem_addr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d miss_count", i), 32'(bus.miss_count), 32'(vecs[i].expCount));
    end

    // Slow memory: late ack, gappy words, pc change and flush mid-fill
    applyStimulus(1, 32'h400, 0, 0, 0, 0);
    checkOutput("slow miss hit", 32'(bus.hit), 32'h0);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1, 32'h400, 0, (c == 5), 0, 0);
      checkOutput($sformatf("slow req%0d", c), 32'(bus.mem_req), 32'h1);
      checkOutput($sformatf("slow addr%0d", c), bus.mem_addr, 32'h400);
      checkOutput($sformatf("slow hit%0d", c), 32'(bus.hit), 32'h0);
    end
    checkOutput("slow miss_count", 32'(bus.miss_count), 32'h5);
    pat = '{1, 0, 0, 1, 1, 0, 1};
    wi = 0;
    for (int c = 0; c < 7; c++) begin
      applyStimulus(1, 32'h0, (c == 1), 0, pat[c][0], pat[c] != 0 ? 32'hC0 + 32'(wi) : 32'hFFFF);
      if (pat[c] != 0) wi++;
      checkOutput($sformatf("slow fill hit%0d", c), 32'(bus.hit), 32'h0);
      checkOutput($sformatf("slow fill req%0d", c), 32'(bus.mem_req), 32'h0);
    end
    applyStimulus(1, 32'h0, 0, 0, 0, 0);
    checkOutput("slow install hit", 32'(bus.hit), 32'h0);
    for (int w = 0; w < 4; w++) begin
      applyStimulus(1, 32'h400 + 32'(4 * w), 0, 0, 0, 0);
      checkOutput($sformatf("slow word%0d hit", w), 32'(bus.hit), 32'h1);
      checkOutput($sformatf("slow word%0d instruction", w), bus.instruction, 32'hC0 + 32'(w));
    end

    // Reset after two of four words
    applyStimulus(1, 32'h800, 0, 0, 0, 0);
    applyStimulus(1, 32'h800, 0, 1, 0, 0);
    checkOutput("abort req", 32'(bus.mem_req), 32'h1);
    checkOutput("abort addr", bus.mem_addr, 32'h800);
    applyStimulus(1, 32'h800, 0, 0, 1, 32'hD0);
    applyStimulus(1, 32'h800, 0, 0, 1, 32'hD1);
    applyStimulus(0, 32'h800, 0, 0, 1, 32'hD2);
    checkOutput("abort rst hit", 32'(bus.hit), 32'h0);
    checkOutput("abort rst instruction", bus.instruction, 32'h0);
    applyStimulus(1, 32'h0, 0, 0, 1, 32'hD3);
    checkOutput("abort mem_req", 32'(bus.mem_req), 32'h0);
    checkOutput("abort miss_count", 32'(bus.miss_count), 32'h0);
    checkOutput("abort relookup hit", 32'(bus.hit), 32'h0);
    applyStimulus(1, 32'h0, 0, 1, 1, 32'h1111);
    checkOutput("abort new req", 32'(bus.mem_req), 32'h1);
    checkOutput("abort new addr", bus.mem_addr, 32'h0);
    checkOutput("abort new count", 32'(bus.miss_count), 32'h1);
    for (int k = 0; k < 4; k++) applyStimulus(1, 32'h0, 0, 0, 1, 32'hE0 + 32'(k));
    applyStimulus(1, 32'h0, 0, 0, 0, 0);
    applyStimulus(1, 32'h8, 0, 0, 0, 0);
    checkOutput("abort refill hit", 32'(bus.hit), 32'h1);
    checkOutput("abort refill instruction", bus.instruction, 32'hE2);

    // Counter wrap: preload near the top instead of spending 65536 refills
    applyStimulus(1, 32'h0, 0, 0, 0, 0);
    force dut.missCount_q = 16'hFFFF;
    #1;
    release dut.missCount_q;
    applyStimulus(1, 32'h1000, 0, 0, 0, 0);
    checkOutput("wrap preload", 32'(bus.miss_count), 32'hFFFF);
    checkOutput("wrap miss hit", 32'(bus.hit), 32'h0);
    applyStimulus(1, 32'h1000, 0, 0, 0, 0);
    checkOutput("wrap miss_count", 32'(bus.miss_count), 32'h0);
    checkOutput("wrap mem_req", 32'(bus.mem_req), 32'h1);

    // Random run against the behavioural model
    doReset();
    foreach (mValid[i]) mValid[i] = 0;
    mBusy = 0; mAcked = 0; mGot = 0; mAckWait = 0; mBlock = '0; mCount = '0;
    pcv = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0)
        pcv = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
      fl        = ($urandom_range(0, 15) == 0);
      expReq    = mBusy && !mAcked;
      ack       = expReq && (mAckWait == 0);
      streaming = mBusy && mAcked && (mGot < 4);
      rv        = streaming ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rd        = (streaming && rv) ? memWord(mBlock + 32'(4 * mGot)) : $urandom();
      applyStimulus(1, pcv, fl, ack, rv, rd);

      idx    = pcv[8:4];
      expHit = !mBusy && !fl && mValid[idx] && (mTag[idx] == pcv[31:9]);
      checkOutput($sformatf("rnd%0d hit", cyc), 32'(bus.hit), 32'(expHit));
      if (expHit) checkOutput($sformatf("rnd%0d instruction", cyc), bus.instruction, mData[idx][pcv[3:2]]);
      checkOutput($sformatf("rnd%0d mem_req", cyc), 32'(bus.mem_req), 32'(expReq));
      if (expReq) checkOutput($sformatf("rnd%0d mem_addr", cyc), bus.mem_addr, mBlock);
      checkOutput($sformatf("rnd%0d miss_count", cyc), 32'(bus.miss_count), 32'(mCount));

      if (fl) foreach (mValid[i]) mValid[i] = 0;
      if (!mBusy) begin
        if (!expHit) begin
          mBusy = 1; mAcked = 0;
          mBlock = {pcv[31:4], 4'b0};
          mCount = mCount + 16'd1;
          mAckWait = $urandom_range(0, 3);
        end
      end else if (!mAcked) begin
        if (ack) begin
          mAcked = 1; mGot = 0;
        end else begin
          mAckWait--;
        end
      end else if (mGot < 4) begin
        if (rv) begin
          mBuf[mGot] = rd;
          mGot++;
        end
      end else begin
        li = mBlock[8:4];
        mTag[li] = mBlock[31:9];
        for (int k = 0; k < 4; k++) mData[li][k] = mBuf[k];
        mValid[li] = 1;
        mBusy = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
